change_dispenser: RTL and testbench

Pays out a change amount as a sequence of physical coins through the coin hopper. This is the output side of the vending datapath: the coin-accepting front end produces a change value, and this block turns it into one-hot coin ejections using the same 1/2/5 encoding. It selects coins greedily, keeps a per-denomination inventory, and reports a shortfall when it cannot pay the full amount.

---
 rtl/vm_pkg.sv | 31 +++
 rtl/change_dispenser_coin_select.sv | 48 ++++
 rtl/change_dispenser.sv | 151 +++++++++++++++
 tb/tb_change_dispenser.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vm_pkg
// Purpose  : Shared vending-machine definitions. These are the coin encodings
//            and values used by both the coin-accepting front end and the
//            change dispenser, plus the dispenser state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package vm_pkg;

    // One-hot coin encodings shared across the vending datapath
    localparam logic [2:0] COIN_NONE = 3'b000;
    localparam logic [2:0] COIN_1    = 3'b001;
    localparam logic [2:0] COIN_2    = 3'b010;
    localparam logic [2:0] COIN_5    = 3'b100;

    // Face value of each denomination, in currency units
    localparam int unsigned VAL_1 = 1;
    localparam int unsigned VAL_2 = 2;
    localparam int unsigned VAL_5 = 5;

    // Change-dispenser FSM states
    typedef enum logic [1:0] {
        DISP_IDLE   = 2'd0,
        DISP_SELECT = 2'd1,
        DISP_PAY    = 2'd2,
        DISP_DONE   = 2'd3
    } disp_state_t;

endpackage : vm_pkg
`default_nettype wire

// File: rtl/change_dispenser_coin_select.sv
`default_nettype none
// ============================================================================
// Module   : coin_select
// Purpose  : Greedy coin picker. Chooses the largest denomination that both
//            fits in the remaining amount and is still in stock.
// Revision : 1.0 - initial release
// ============================================================================
module coin_select
    import vm_pkg::*;
#(
    parameter int AMT_W = 4,
    parameter int INV_W = 6
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [INV_W-1:0] inv_1,
    input  logic [INV_W-1:0] inv_2,
    input  logic [INV_W-1:0] inv_5,
    output logic             sel_valid,
    output logic [2:0]       sel_coin,
    output logic [AMT_W-1:0] sel_value
);

    // Compare at 32 bits so narrow AMT_W settings never truncate the values
    logic [31:0] w_rem32;
    assign w_rem32 = 32'(remaining);

    // Priority pick 5 -> 2 -> 1; a denomination qualifies only when in stock
    always_comb begin
        sel_valid = 1'b0;
        sel_coin  = COIN_NONE;
        sel_value = '0;
        if ((w_rem32 >= VAL_5) && (|inv_5)) begin
            sel_valid = 1'b1;
            sel_coin  = COIN_5;
            sel_value = AMT_W'(VAL_5);
        end else if ((w_rem32 >= VAL_2) && (|inv_2)) begin
            sel_valid = 1'b1;
            sel_coin  = COIN_2;
            sel_value = AMT_W'(VAL_2);
        end else if ((w_rem32 >= VAL_1) && (|inv_1)) begin
            sel_valid = 1'b1;
            sel_coin  = COIN_1;
            sel_value = AMT_W'(VAL_1);
        end
    end

endmodule : coin_select
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays a change amount as a sequence of one-hot coin ejections,
//            tracks per-denomination inventory and flags shortfalls.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser
    import vm_pkg::*;
#(
    parameter int AMT_W    = 4,
    parameter int INV_W    = 6,
    parameter int INV_INIT = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic [2:0]       coin,
    output logic             coin_valid,
    input  logic             coin_ack,
    input  logic             refill,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic [INV_W-1:0] inv_1,
    output logic [INV_W-1:0] inv_2,
    output logic [INV_W-1:0] inv_5
);

    localparam logic [INV_W-1:0] c_INV_INIT = INV_W'(INV_INIT);
    localparam logic [INV_W-1:0] c_INV_ONE  = INV_W'(1);

    disp_state_t      r_state;
    logic [2:0]       r_coin;
    logic             r_coin_valid;
    logic [AMT_W-1:0] r_coin_value;
    logic             r_done;
    logic             r_short;
    logic [AMT_W-1:0] r_remaining;
    logic [INV_W-1:0] r_inv_1;
    logic [INV_W-1:0] r_inv_2;
    logic [INV_W-1:0] r_inv_5;

    logic             w_sel_valid;
    logic [2:0]       w_sel_coin;
    logic [AMT_W-1:0] w_sel_value;

    coin_select #(
        .AMT_W (AMT_W),
        .INV_W (INV_W)
    ) u_coin_select (
        .remaining (r_remaining),
        .inv_1     (r_inv_1),
        .inv_2     (r_inv_2),
        .inv_5     (r_inv_5),
        .sel_valid (w_sel_valid),
        .sel_coin  (w_sel_coin),
        .sel_value (w_sel_value)
    );

    // Dispense FSM with its coin, status and inventory registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= DISP_IDLE;
            r_coin       <= COIN_NONE;
            r_coin_valid <= 1'b0;
            r_coin_value <= '0;
            r_done       <= 1'b0;
            r_short      <= 1'b0;
            r_remaining  <= '0;
            r_inv_1      <= c_INV_INIT;
            r_inv_2      <= c_INV_INIT;
            r_inv_5      <= c_INV_INIT;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DISP_IDLE: begin
                    // Refill lands at the same edge as a request, so SELECT
                    // already works from the reloaded counts
                    if (refill) begin
                        r_inv_1 <= c_INV_INIT;
                        r_inv_2 <= c_INV_INIT;
                        r_inv_5 <= c_INV_INIT;
                    end
                    if (req_valid) begin
                        r_remaining <= req_amount;
                        if (req_amount == '0) begin
                            r_state <= DISP_DONE;
                            r_done  <= 1'b1;
                            r_short <= 1'b0;
                        end else begin
                            r_state <= DISP_SELECT;
                        end
                    end
                end
                DISP_SELECT: begin
                    if (r_remaining == '0) begin
                        r_state <= DISP_DONE;
                        r_done  <= 1'b1;
                        r_short <= 1'b0;
                    end else if (!w_sel_valid) begin
                        // Out of usable coins: remaining keeps the unpaid part
                        r_state <= DISP_DONE;
                        r_done  <= 1'b1;
                        r_short <= 1'b1;
                    end else begin
                        r_coin       <= w_sel_coin;
                        r_coin_valid <= 1'b1;
                        r_coin_value <= w_sel_value;
                        r_state      <= DISP_PAY;
                    end
                end
                DISP_PAY: begin
                    // Coin is only committed once the hopper takes it
                    if (coin_ack && r_coin_valid) begin
                        r_remaining <= r_remaining - r_coin_value;
                        case (r_coin)
                            COIN_1:  r_inv_1 <= r_inv_1 - c_INV_ONE;
                            COIN_2:  r_inv_2 <= r_inv_2 - c_INV_ONE;
                            COIN_5:  r_inv_5 <= r_inv_5 - c_INV_ONE;
                            default: ;
                        endcase
                        r_coin       <= COIN_NONE;
                        r_coin_valid <= 1'b0;
                        r_state      <= DISP_SELECT;
                    end
                end
                DISP_DONE: begin
                    // short is only meaningful alongside the done pulse
                    r_short <= 1'b0;
                    r_state <= DISP_IDLE;
                end
                default: r_state <= DISP_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == DISP_IDLE);
    assign coin       = r_coin;
    assign coin_valid = r_coin_valid;
    assign done       = r_done;
    assign short      = r_short;
    assign remaining  = r_remaining;
    assign inv_1      = r_inv_1;
    assign inv_2      = r_inv_2;
    assign inv_5      = r_inv_5;

endmodule : change_dispenser
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Self-checking bench for change_dispenser. Main instance runs
//            with default inventory; a second instance with single-coin
//            inventory covers shortfall and refill behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    int         cyc = 0;

    // Main instance (INV_INIT = 20)
    logic       req_valid = 1'b0;
    logic [3:0] req_amount = '0;
    logic       req_ready;
    logic [2:0] coin;
    logic       coin_valid;
    logic       coin_ack = 1'b0;
    logic       refill = 1'b0;
    logic       done;
    logic       short;
    logic [3:0] remaining;
    logic [5:0] inv_1, inv_2, inv_5;

    // Small-stock instance (INV_INIT = 1), hopper always ready
    logic       req_valid_s = 1'b0;
    logic [3:0] req_amount_s = '0;
    logic       req_ready_s;
    logic [2:0] coin_s;
    logic       coin_valid_s;
    logic       coin_ack_s = 1'b1;
    logic       refill_s = 1'b0;
    logic       done_s;
    logic       short_s;
    logic [3:0] remaining_s;
    logic [5:0] inv_1_s, inv_2_s, inv_5_s;

    change_dispenser #(.AMT_W(4), .INV_W(6), .INV_INIT(20)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .coin(coin), .coin_valid(coin_valid), .coin_ack(coin_ack),
        .refill(refill), .done(done), .short(short), .remaining(remaining),
        .inv_1(inv_1), .inv_2(inv_2), .inv_5(inv_5)
    );

    change_dispenser #(.AMT_W(4), .INV_W(6), .INV_INIT(1)) dut_s (
        .clk(clk), .reset(reset), .req_valid(req_valid_s), .req_amount(req_amount_s),
        .req_ready(req_ready_s), .coin(coin_s), .coin_valid(coin_valid_s), .coin_ack(coin_ack_s),
        .refill(refill_s), .done(done_s), .short(short_s), .remaining(remaining_s),
        .inv_1(inv_1_s), .inv_2(inv_2_s), .inv_5(inv_5_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int kind;   // 0 = coin presented, 1 = done
        int coinv;
        int cycle;  // expected cycle, -1 = don't care
        int shrt;
        int rem;
    } exp_t;
    exp_t sb[$];
    int done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input int kind, input int coinv, input int cycle,
                                 input int shrt, input int rem);
        exp_t e;
        e.kind = kind; e.coinv = coinv; e.cycle = cycle; e.shrt = shrt; e.rem = rem;
        sb.push_back(e);
    endfunction

    // Hopper model: ack after coin_valid has been high for ack_delay cycles
    int ack_delay = 0;
    int wait_cnt  = 0;
    initial forever begin
        @(negedge clk);
        if (coin_valid) begin
            coin_ack = (wait_cnt >= ack_delay);
            wait_cnt++;
        end else begin
            coin_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor: pops the scoreboard on each new coin and on each done pulse
    logic       prev_cv = 1'b0;
    logic [2:0] held_coin = '0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
            prev_cv = 1'b0;
        end else begin
            if (coin_valid && !prev_cv) begin
                held_coin = coin;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_coin: got coin %b with nothing expected (cycle %0d)", coin, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_coin", 0, e.kind);
                    chk("coin_value", int'(coin), e.coinv);
                    if (e.cycle >= 0) chk("coin_cycle", cyc, e.cycle);
                end
            end else if (coin_valid && prev_cv) begin
                chk("coin_stable", int'(coin), int'(held_coin));
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done: got done with nothing expected (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind_done", 1, e.kind);
                    chk("done_short", int'(short), e.shrt);
                    chk("done_remaining", int'(remaining), e.rem);
                    if (e.cycle >= 0) chk("done_cycle", cyc, e.cycle);
                end
            end
            prev_cv = coin_valid;
        end
    end

    // Present a request on the main instance; k is the acceptance cycle
    task automatic issue(input logic [3:0] amt, output int k);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("req_ready_timeout", 0, 1);
        req_valid  = 1'b1;
        req_amount = amt;
        k = cyc;
    endtask

    task automatic release_req();
        @(negedge clk);
        req_valid = 1'b0;
        refill    = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_cnt < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < target) chk("done_timeout", done_cnt, target);
    endtask

    // Request on the small-stock instance; returns in cycle k+1
    task automatic sreq(input logic [3:0] amt, input logic with_refill);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready_s && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready_s) chk("req_ready_s_timeout", 0, 1);
        req_valid_s  = 1'b1;
        req_amount_s = amt;
        refill_s     = with_refill;
        @(negedge clk);
        req_valid_s  = 1'b0;
        refill_s     = 1'b0;
    endtask

    task automatic chk_coin_s(input string name, input int exp_coin);
        chk({name, "_valid"}, int'(coin_valid_s), 1);
        chk(name, int'(coin_s), exp_coin);
    endtask

    initial begin
        int k;
        int exp_done;
        exp_done = 0;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_coin", int'(coin), 0);
        chk("rst_coin_valid", int'(coin_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_inv_1", int'(inv_1), 20);
        chk("rst_inv_2", int'(inv_2), 20);
        chk("rst_inv_5", int'(inv_5), 20);

        // Two 2-coins, hopper always ready
        ack_delay = 0;
        issue(4'd4, k);
        push(0, 3'b010, k + 2, 0, 0);
        push(0, 3'b010, k + 4, 0, 0);
        push(1, 0, k + 6, 0, 0);
        exp_done++;
        release_req();
        wait_done(exp_done);
        chk("t1_inv_2", int'(inv_2), 18);
        chk("t1_inv_1", int'(inv_1), 20);
        chk("t1_inv_5", int'(inv_5), 20);

        // Mixed coins 5+2+1
        issue(4'd8, k);
        push(0, 3'b100, k + 2, 0, 0);
        push(0, 3'b010, k + 4, 0, 0);
        push(0, 3'b001, k + 6, 0, 0);
        push(1, 0, k + 8, 0, 0);
        exp_done++;
        release_req();
        wait_done(exp_done);
        chk("t2_inv_5", int'(inv_5), 19);
        chk("t2_inv_2", int'(inv_2), 17);
        chk("t2_inv_1", int'(inv_1), 19);

        // Slow hopper: coin held k+2..k+5, ack in k+5, SELECT k+6, done k+7
        ack_delay = 3;
        issue(4'd2, k);
        push(0, 3'b010, k + 2, 0, 0);
        push(1, 0, k + 7, 0, 0);
        exp_done++;
        release_req();
        repeat (4) @(negedge clk);
        chk("t3_held_k5_valid", int'(coin_valid), 1);
        chk("t3_no_early_dec", int'(inv_2), 17);
        wait_done(exp_done);
        chk("t3_inv_2", int'(inv_2), 16);
        chk("t3_inv_5", int'(inv_5), 19);

        // Reset during PAY: coin never acked, then reset
        ack_delay = 1000;
        issue(4'd5, k);
        push(0, 3'b100, k + 2, 0, 0);
        release_req();
        @(negedge clk);
        chk("t4_in_pay", int'(coin_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t4_coin_valid", int'(coin_valid), 0);
        chk("t4_coin", int'(coin), 0);
        chk("t4_inv_5", int'(inv_5), 20);
        chk("t4_inv_2", int'(inv_2), 20);
        chk("t4_remaining", int'(remaining), 0);
        chk("t4_req_ready", int'(req_ready), 1);
        reset = 1'b0;
        ack_delay = 0;

        // Zero request: done in k+1
        issue(4'd0, k);
        push(1, 0, k + 1, 0, 0);
        exp_done++;
        release_req();
        wait_done(exp_done);
        chk("t5_inv_1", int'(inv_1), 20);

        // Shortfall on small stock: 10 -> 5,2,1 then short with 2 unpaid
        sreq(4'd10, 1'b0);                       // now k+1
        @(negedge clk); chk_coin_s("s1_coin_a", 3'b100);   // k+2
        repeat (2) @(negedge clk); chk_coin_s("s1_coin_b", 3'b010); // k+4
        repeat (2) @(negedge clk); chk_coin_s("s1_coin_c", 3'b001); // k+6
        @(negedge clk); chk("s1_no_early_done", int'(done_s), 0);   // k+7
        @(negedge clk);                                              // k+8
        chk("s1_done", int'(done_s), 1);
        chk("s1_short", int'(short_s), 1);
        chk("s1_remaining", int'(remaining_s), 2);
        chk("s1_inv_1", int'(inv_1_s), 0);
        chk("s1_inv_2", int'(inv_2_s), 0);
        chk("s1_inv_5", int'(inv_5_s), 0);

        // Refill together with req 3 after depletion
        sreq(4'd3, 1'b1);
        @(negedge clk); chk_coin_s("s2_coin_a", 3'b010);
        repeat (2) @(negedge clk); chk_coin_s("s2_coin_b", 3'b001);
        repeat (2) @(negedge clk);
        chk("s2_done", int'(done_s), 1);
        chk("s2_short", int'(short_s), 0);
        chk("s2_remaining", int'(remaining_s), 0);
        chk("s2_inv_5", int'(inv_5_s), 1);
        chk("s2_inv_2", int'(inv_2_s), 0);

        // Refill pulsed during PAY is ignored
        sreq(4'd5, 1'b0);
        @(negedge clk); chk_coin_s("s3_coin", 3'b100);      // k+2, PAY
        refill_s = 1'b1;
        @(negedge clk);
        refill_s = 1'b0;
        @(negedge clk);                                     // k+4
        chk("s3_done", int'(done_s), 1);
        chk("s3_inv_5", int'(inv_5_s), 0);
        chk("s3_inv_1", int'(inv_1_s), 0);
        chk("s3_inv_2", int'(inv_2_s), 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_change_dispenser
`default_nettype wire
